// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Seven-segment glyph table and shared constants for seg_driver.
// Revision : 1.0
// ============================================================================
package seg_pkg;

    localparam int SEG_W = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // Active-high segment codes, bit order a b c d e f g dp (dp never lit)
    function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] i_nib);
        logic [SEG_W-1:0] w_code;
        w_code = 8'h00;
        case (i_nib)
            4'h0: w_code = 8'hFC;
            4'h1: w_code = 8'h60;
            4'h2: w_code = 8'hDA;
            4'h3: w_code = 8'hF2;
            4'h4: w_code = 8'h66;
            4'h5: w_code = 8'hB6;
            4'h6: w_code = 8'hBE;
            4'h7: w_code = 8'hE0;
            4'h8: w_code = 8'hFE;
            4'h9: w_code = 8'hF6;
            4'hA: w_code = 8'hEE;
            4'hB: w_code = 8'h3E;
            4'hC: w_code = 8'h9C;
            4'hD: w_code = 8'h7A;
            4'hE: w_code = 8'h9E;
            4'hF: w_code = 8'h8E;
            default: w_code = 8'h00;
        endcase
        return w_code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_hex_decoder
// Brief    : Combinational 4-bit hex to active-low seven-segment decoder.
// Revision : 1.0
// ============================================================================
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0]       i_hex,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = ~hex2seg(i_hex);

endmodule
`default_nettype wire

// File: rtl/seg_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_driver
// Brief    : Free-running 32-bit counter shown in hex on eight 7-seg digits.
// Revision : 1.0
// ============================================================================
module seg_driver
    import seg_pkg::*;
#(
    parameter int PRESCALE = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [SEG_W-1:0] o_seg0,
    output logic [SEG_W-1:0] o_seg1,
    output logic [SEG_W-1:0] o_seg2,
    output logic [SEG_W-1:0] o_seg3,
    output logic [SEG_W-1:0] o_seg4,
    output logic [SEG_W-1:0] o_seg5,
    output logic [SEG_W-1:0] o_seg6,
    output logic [SEG_W-1:0] o_seg7
);

    localparam int                 c_PS_W     = $clog2(PRESCALE + 1);
    localparam logic [c_PS_W-1:0]  c_PS_LAST  = c_PS_W'(PRESCALE - 1);
    localparam logic [c_PS_W-1:0]  c_PS_ONE   = c_PS_W'(1);
    localparam logic [SEG_W-1:0]   c_SEG_ZERO = ~hex2seg(4'h0);

    logic [c_PS_W-1:0] r_presc;
    logic [31:0]       r_value;
    logic [SEG_W-1:0]  r_seg [8];
    logic [SEG_W-1:0]  w_seg [8];

    generate
        for (genvar k = 0; k < 8; k++) begin : g_digit
            seg_hex_decoder u_dec (
                .i_hex (r_value[4*k +: 4]),
                .o_seg (w_seg[k])
            );
        end
    endgenerate

    // Outputs lag the value by one clock so all digits switch together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_value <= '0;
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= c_SEG_ZERO;
            end
        end else begin
            if (r_presc == c_PS_LAST) begin
                r_presc <= '0;
                r_value <= r_value + 32'd1;
            end else begin
                r_presc <= r_presc + c_PS_ONE;
            end
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= w_seg[k];
            end
        end
    end

    assign o_seg0 = r_seg[0];
    assign o_seg1 = r_seg[1];
    assign o_seg2 = r_seg[2];
    assign o_seg3 = r_seg[3];
    assign o_seg4 = r_seg[4];
    assign o_seg5 = r_seg[5];
    assign o_seg6 = r_seg[6];
    assign o_seg7 = r_seg[7];

endmodule
`default_nettype wire

// File: tb/tb_seg_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_driver
// Brief    : Directed self-checking bench for seg_driver (PRESCALE 4 and 1).
// Revision : 1.0
// ============================================================================
module tb_seg_driver;

    localparam logic [63:0] c_ALL_ZERO = {8{8'h03}};
    localparam logic [7:0]  c_GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    logic clk;
    logic rst4;
    logic rst1;
    logic started;
    int   n_chk;
    int   n_err;

    logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7;
    logic [63:0] w_seg4;
    logic [63:0] w_seg1;

    assign w_seg4 = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign w_seg1 = {b7, b6, b5, b4, b3, b2, b1, b0};

    seg_driver #(.PRESCALE(4)) dut4 (
        .clk (clk), .rst (rst4),
        .o_seg0 (a0), .o_seg1 (a1), .o_seg2 (a2), .o_seg3 (a3),
        .o_seg4 (a4), .o_seg5 (a5), .o_seg6 (a6), .o_seg7 (a7)
    );

    seg_driver #(.PRESCALE(1)) dut1 (
        .clk (clk), .rst (rst1),
        .o_seg0 (b0), .o_seg1 (b1), .o_seg2 (b2), .o_seg3 (b3),
        .o_seg4 (b4), .o_seg5 (b5), .o_seg6 (b6), .o_seg7 (b7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Decimal point must stay dark on every digit of both instances
    always @(negedge clk) begin
        if (started) begin
            check("dp_dark",
                  {48'h0, a7[0], a6[0], a5[0], a4[0], a3[0], a2[0], a1[0], a0[0],
                   b7[0], b6[0], b5[0], b4[0], b3[0], b2[0], b1[0], b0[0]},
                  64'hFFFF);
        end
    end

    initial begin
        n_chk   = 0;
        n_err   = 0;
        started = 1'b0;
        rst4    = 1'b1;
        rst1    = 1'b1;

        // Reset takes effect before any clock edge
        #2;
        rst4 = 1'b0;
        rst1 = 1'b0;
        #1;
        check("rst_async4", w_seg4, c_ALL_ZERO);
        check("rst_async1", w_seg1, c_ALL_ZERO);
        started = 1'b1;
        step(3);
        check("rst_hold", w_seg4, c_ALL_ZERO);

        // Counting with PRESCALE=4
        rst4 = 1'b1;
        step(4);
        check("cnt_edge4", w_seg4, c_ALL_ZERO);
        step(1);
        check("cnt_one", w_seg4, {{7{8'h03}}, 8'h9F});
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("cnt_hold", w_seg4, {{7{8'h03}}, 8'h9F});
        end
        step(1);
        check("cnt_two", w_seg4, {{7{8'h03}}, 8'h25});

        // 9 edges so far; 13 more gives value=5, prescaler=2
        step(13);
        check("mid_pre", w_seg4, {{7{8'h03}}, 8'h49});
        rst4 = 1'b0;
        #1;
        check("mid_async", w_seg4, c_ALL_ZERO);
        #1;
        rst4 = 1'b1;
        step(4);
        check("mid_edge4", w_seg4, c_ALL_ZERO);
        step(1);
        check("mid_one", w_seg4, {{7{8'h03}}, 8'h9F});

        // Glyph walk with PRESCALE=1: output shows value from the previous edge
        rst1 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(1);
            check("glyph", {56'h0, b0}, {56'h0, c_GLYPH[i % 16]});
            if (i == 15) check("glyph_d1_pre", {56'h0, b1}, 64'h03);
            if (i == 16) check("glyph_carry", {56'h0, b1}, 64'h9F);
        end

        // Wrap-around and full-pattern decode via hierarchical deposit
        dut1.r_value = 32'hFFFF_FFFF;
        step(1);
        check("wrap_pre", w_seg1, {8{8'h71}});
        step(1);
        check("wrap", w_seg1, c_ALL_ZERO);
        dut1.r_value = 32'h89AB_CDEF;
        step(1);
        check("pattern", w_seg1, 64'h01_09_11_C1_63_85_61_71);

        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
